// File: rtl/cvm_capture_pkg.sv
// Shared types and helpers for the CVM300 frame capture block.
package cvm_capture_pkg;

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_CFG,
        S_IDLE,
        S_GAP,
        S_REQ,
        S_CAP
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hF5A5;

    function automatic int pix_per_word(input int word_w, input int out_pix_w);
        return word_w / out_pix_w;
    endfunction

endpackage

// File: rtl/cvm_pixel_packer.sv
// Packs truncated pixels LSB-first into words and holds each word until accepted;
// a word completing while another is still pending is dropped and flagged.
module cvm_pixel_packer
    import cvm_capture_pkg::*;
#(
    parameter int OUT_PIX_W = 8,
    parameter int WORD_W    = 32
) (
    input  logic                 CVM_Clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 discard,
    input  logic                 pix_vld,
    input  logic [OUT_PIX_W-1:0] pix,
    input  logic                 flush,
    input  logic                 hdr_vld,
    input  logic [WORD_W-1:0]    hdr,
    output logic [WORD_W-1:0]    word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overflow
);
    localparam int PPW   = pix_per_word(WORD_W, OUT_PIX_W);
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [WORD_W-1:0] acc, acc_nxt, done_word;
    logic [IDX_W-1:0]  idx;
    logic              last_pix, done;

    assign acc_nxt  = acc | (WORD_W'(pix) << (idx * OUT_PIX_W));
    assign last_pix = (idx == IDX_W'(PPW - 1));

    always_comb begin
        done      = 1'b0;
        done_word = acc_nxt;
        if (hdr_vld) begin
            done      = 1'b1;
            done_word = hdr;
        end else if (pix_vld && last_pix) begin
            done = 1'b1;
        end else if (flush && idx != '0) begin
            // partial word goes out zero-padded; unused lanes were never written
            done      = 1'b1;
            done_word = acc;
        end
    end

    always_ff @(posedge CVM_Clk) begin
        if (reset) begin
            acc        <= '0;
            idx        <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (discard) begin
            acc        <= '0;
            idx        <= '0;
            word_valid <= 1'b0;
        end else begin
            if (clr) begin
                acc      <= '0;
                idx      <= '0;
                overflow <= 1'b0;
            end else if (pix_vld) begin
                acc <= last_pix ? '0 : acc_nxt;
                idx <= last_pix ? '0 : idx + 1'b1;
            end else if (flush) begin
                acc <= '0;
                idx <= '0;
            end
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            if (done) begin
                if (word_valid && !word_ready) begin
                    overflow <= 1'b1;
                end else begin
                    word_data  <= done_word;
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cvm_frame_capture.sv
// CVM300 power-up, frame request and ROI burst capture into packed words.
// Define CVM_FRAME_HEADER_EN to emit a header word ahead of each frame's pixels.
module cvm_frame_capture
    import cvm_capture_pkg::*;
#(
    parameter int PIX_W       = 10,
    parameter int OUT_PIX_W   = 8,
    parameter int WORD_W      = 32,
    parameter int LINE_PIXELS = 648,
    parameter int FRAME_LINES = 488,
    parameter int RESET_HOLD  = 65535,
    parameter int CFG_WAIT    = 4095,
    parameter int REQ_GAP     = 255
) (
    input  logic                           CVM_Clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [7:0]                     frame_count,
    input  logic [$clog2(LINE_PIXELS)-1:0] roi_x0,
    input  logic [$clog2(LINE_PIXELS)-1:0] roi_x1,
    input  logic [$clog2(FRAME_LINES)-1:0] roi_y0,
    input  logic [$clog2(FRAME_LINES)-1:0] roi_y1,
    input  logic [PIX_W-1:0]               CVM_D,
    input  logic                           CVM_Line_valid,
    input  logic                           CVM_Data_valid,
    output logic                           SYS_RES_N,
    output logic                           FRAME_REQ,
    output logic                           spi_ready,
    output logic                           fifo_reset,
    output logic [WORD_W-1:0]              word_data,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic                           busy,
    output logic [7:0]                     frames_done,
    output logic                           overflow
);
    localparam int COL_W    = $clog2(LINE_PIXELS);
    localparam int ROW_W    = $clog2(FRAME_LINES + 1);
    localparam int YW       = $clog2(FRAME_LINES);
    localparam int MAX_WAIT = (RESET_HOLD > CFG_WAIT)
                            ? ((RESET_HOLD > REQ_GAP) ? RESET_HOLD : REQ_GAP)
                            : ((CFG_WAIT > REQ_GAP) ? CFG_WAIT : REQ_GAP);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [COL_W-1:0]  col, x0_l, x1_l;
    logic [ROW_W-1:0]  row;
    logic [YW-1:0]     y0_l, y1_l;
    logic [7:0]        count_lat, frames_inc;
    logic              lv_q, frame_end, in_roi, pix_vld, run_st, hdr_vld;
    logic [WORD_W-1:0] hdr;
    logic              unused_lsbs;

    assign unused_lsbs = ^CVM_D;
    assign run_st      = (state == S_GAP) || (state == S_REQ) || (state == S_CAP);
    assign frame_end   = (state == S_CAP) && (row == ROW_W'(FRAME_LINES));
    assign frames_inc  = frames_done + 8'd1;
    assign in_roi      = (col >= x0_l) && (col <= x1_l) &&
                         (row >= ROW_W'(y0_l)) && (row <= ROW_W'(y1_l));
    assign pix_vld     = (state == S_CAP) && !abort && !frame_end &&
                         CVM_Line_valid && CVM_Data_valid && in_roi;

    always_comb begin
        state_nxt  = state;
        SYS_RES_N  = (state != S_RST_HOLD);
        spi_ready  = (state != S_RST_HOLD) && (state != S_CFG);
        FRAME_REQ  = (state == S_REQ);
        fifo_reset = !run_st;
        busy       = run_st;
        case (state)
            S_RST_HOLD: if (cnt == CNT_W'(RESET_HOLD)) state_nxt = S_CFG;
            S_CFG:      if (cnt == CNT_W'(CFG_WAIT))   state_nxt = S_IDLE;
            S_IDLE:     if (start)                     state_nxt = S_GAP;
            S_GAP:      if (abort)                     state_nxt = S_IDLE;
                        else if (cnt == CNT_W'(REQ_GAP)) state_nxt = S_REQ;
            S_REQ:      if (abort)                     state_nxt = S_IDLE;
                        else if (cnt == CNT_W'(1))     state_nxt = S_CAP;
            S_CAP:      if (abort)                     state_nxt = S_IDLE;
                        else if (frame_end)
                            state_nxt = (frames_inc < count_lat) ? S_GAP : S_IDLE;
            default:    state_nxt = S_RST_HOLD;
        endcase
    end

    always_ff @(posedge CVM_Clk) begin
        if (reset) begin
            state       <= S_RST_HOLD;
            cnt         <= '0;
            col         <= '0;
            row         <= '0;
            lv_q        <= 1'b0;
            frames_done <= 8'd0;
            count_lat   <= 8'd1;
            x0_l        <= '0;
            x1_l        <= '0;
            y0_l        <= '0;
            y1_l        <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
            if (state == S_IDLE && start) begin
                count_lat   <= (frame_count == 8'd0) ? 8'd1 : frame_count;
                x0_l        <= roi_x0;
                x1_l        <= roi_x1;
                y0_l        <= roi_y0;
                y1_l        <= roi_y1;
                frames_done <= 8'd0;
            end
            // position counters only live during capture; anything else rearms them
            if (state == S_CAP && !abort) begin
                lv_q <= CVM_Line_valid;
                if (lv_q && !CVM_Line_valid) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else if (CVM_Line_valid && CVM_Data_valid) begin
                    col <= col + 1'b1;
                end
                if (frame_end)
                    frames_done <= frames_inc;
            end else begin
                col  <= '0;
                row  <= '0;
                lv_q <= 1'b0;
            end
        end
    end

`ifdef CVM_FRAME_HEADER_EN
    logic [31:0] hdr32;
    assign hdr32   = {HDR_MAGIC, 8'h00, frames_done};
    assign hdr     = WORD_W'(hdr32);
    assign hdr_vld = (state == S_REQ) && (state_nxt == S_CAP);
`else
    assign hdr     = '0;
    assign hdr_vld = 1'b0;
`endif

    cvm_pixel_packer #(
        .OUT_PIX_W (OUT_PIX_W),
        .WORD_W    (WORD_W)
    ) u_packer (
        .CVM_Clk    (CVM_Clk),
        .reset      (reset),
        .clr        (state == S_IDLE && start),
        .discard    (abort && run_st),
        .pix_vld    (pix_vld),
        .pix        (CVM_D[PIX_W-1 -: OUT_PIX_W]),
        .flush      (frame_end && !abort),
        .hdr_vld    (hdr_vld),
        .hdr        (hdr),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_cvm_frame_capture.sv
// Directed bench for cvm_frame_capture with a frame-level word model and a per-cycle monitor.
module tb_cvm_frame_capture;
    localparam int PIX_W = 10, OUT_PIX_W = 8, WORD_W = 32;
    localparam int LP = 8, FL = 2, RH = 15, CW = 7, RG = 5;
    localparam int XW = $clog2(LP), YW = $clog2(FL);

    logic              CVM_Clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0]        frame_count = 8'd1;
    logic [XW-1:0]     roi_x0 = '0, roi_x1 = '0;
    logic [YW-1:0]     roi_y0 = '0, roi_y1 = '0;
    logic [PIX_W-1:0]  CVM_D = '0;
    logic              lv = 1'b0, dv = 1'b0, word_ready = 1'b0;
    logic              SYS_RES_N, FRAME_REQ, spi_ready, fifo_reset, word_valid, busy, overflow;
    logic [WORD_W-1:0] word_data;
    logic [7:0]        frames_done;

    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl[$];
    bit   mon_en = 1'b0;
    int   req_pulses = 0, req_run = 0, low_run = 0;
    bit   hold_pending = 1'b0;
    logic [31:0] hold_data = '0;

    cvm_frame_capture #(
        .PIX_W(PIX_W), .OUT_PIX_W(OUT_PIX_W), .WORD_W(WORD_W), .LINE_PIXELS(LP),
        .FRAME_LINES(FL), .RESET_HOLD(RH), .CFG_WAIT(CW), .REQ_GAP(RG)
    ) dut (
        .CVM_Clk(CVM_Clk), .reset(reset), .start(start), .abort(abort),
        .frame_count(frame_count), .roi_x0(roi_x0), .roi_x1(roi_x1),
        .roi_y0(roi_y0), .roi_y1(roi_y1), .CVM_D(CVM_D),
        .CVM_Line_valid(lv), .CVM_Data_valid(dv), .SYS_RES_N(SYS_RES_N),
        .FRAME_REQ(FRAME_REQ), .spi_ready(spi_ready), .fifo_reset(fifo_reset),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .frames_done(frames_done), .overflow(overflow)
    );

    always #5 CVM_Clk = ~CVM_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected word stream of one frame: sensor pixel p sits at row p/LP, col p%LP
    // and stores p mod 256 since D = p<<2.
    function automatic void model_frame(input int x0, input int x1, input int y0, input int y1);
        logic [31:0] w;
        int k;
        mdl.delete();
        w = '0;
        k = 0;
        for (int r = 0; r < FL; r++)
            for (int c = 0; c < LP; c++)
                if (c >= x0 && c <= x1 && r >= y0 && r <= y1) begin
                    w = w | (32'((r * LP + c) % 256) << (8 * k));
                    k++;
                    if (k == 4) begin
                        mdl.push_back(w);
                        w = '0;
                        k = 0;
                    end
                end
        if (k != 0) mdl.push_back(w);
    endfunction

    // Monitor: samples on the falling edge what the next rising edge will act on.
    always @(negedge CVM_Clk) begin
        if (mon_en) begin
            if (word_valid && hold_pending) chk("word_hold", word_data, hold_data);
            hold_pending = word_valid && !word_ready;
            hold_data    = word_data;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", word_data);
                end else begin
                    chk("word", word_data, exp_q.pop_front());
                end
            end
            if (FRAME_REQ) begin
                if (req_run == 0) begin
                    req_pulses++;
                    chk("req_gap_ok", 32'(low_run >= RG), 32'd1);
                end
                req_run++;
                low_run = 0;
            end else begin
                if (req_run != 0) chk("req_width", 32'(req_run), 32'd2);
                req_run = 0;
                low_run = busy ? low_run + 1 : 0;
            end
            chk("fifo_reset_vs_busy", 32'(fifo_reset), 32'(!busy));
        end
    end

    task automatic step();
        @(posedge CVM_Clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] fc, input int x0, input int x1, input int y0, input int y1);
        frame_count = fc;
        roi_x0 = XW'(x0);
        roi_x1 = XW'(x1);
        roi_y0 = YW'(y0);
        roi_y1 = YW'(y1);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_cap();
        int n;
        n = 0;
        while (!FRAME_REQ && n < 300) begin step(); n++; end
        while (FRAME_REQ && n < 300) begin step(); n++; end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL frame_req_timeout: got no pulse expected a FRAME_REQ pulse");
        end
    endtask

    task automatic send_frame(output int first_vld);
        first_vld = -1;
        wait_cap();
        for (int r = 0; r < FL; r++) begin
            for (int c = 0; c < LP; c++) begin
                lv = 1'b1;
                dv = 1'b1;
                CVM_D = PIX_W'((r * LP + c) << 2);
                step();
                if (word_valid && first_vld < 0) first_vld = r * LP + c;
            end
            lv = 1'b0;
            dv = 1'b0;
            CVM_D = '0;
            repeat (3) step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin step(); n++; end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: got busy=1 expected busy=0", name);
        end
        repeat (2) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sys_at, spi_at, fv, p0;
        bit req_seen;

        repeat (3) step();
        chk("rst_sys_res_n", 32'(SYS_RES_N), 32'd0);
        chk("rst_frame_req", 32'(FRAME_REQ), 32'd0);
        chk("rst_spi_ready", 32'(spi_ready), 32'd0);
        chk("rst_fifo_reset", 32'(fifo_reset), 32'd1);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_data", word_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // power-up: SYS_RES_N at cycle RH+1, spi_ready CW+1 cycles later
        reset = 1'b0;
        sys_at = -1;
        spi_at = -1;
        req_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (SYS_RES_N && sys_at < 0) sys_at = i;
            if (spi_ready && spi_at < 0) spi_at = i;
            if (FRAME_REQ) req_seen = 1'b1;
        end
        chk("pwr_sys_res_n_cycle", 32'(sys_at), 32'd16);
        chk("pwr_spi_ready_cycle", 32'(spi_at), 32'd24);
        chk("pwr_no_frame_req", 32'(req_seen), 32'd0);
        word_ready = 1'b1;
        mon_en = 1'b1;

        // full frame, full ROI
        model_frame(0, LP - 1, 0, FL - 1);
        chk("mdl_full_size", 32'(mdl.size()), 32'd4);
        chk("mdl_full_w0", mdl[0], 32'h03020100);
        chk("mdl_full_w1", mdl[1], 32'h07060504);
        chk("mdl_full_w2", mdl[2], 32'h0B0A0908);
        chk("mdl_full_w3", mdl[3], 32'h0F0E0D0C);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        p0 = req_pulses;
        do_start(8'd1, 0, LP - 1, 0, FL - 1);
        chk("start_busy", 32'(busy), 32'd1);
        send_frame(fv);
        wait_idle("full");
        chk("full_first_valid_pixel", 32'(fv), 32'd3);
        chk("full_frames_done", 32'(frames_done), 32'd1);
        chk("full_req_pulses", 32'(req_pulses - p0), 32'd1);
        chk("full_words_left", 32'(exp_q.size()), 32'd0);

        // ROI crop with frame_count=0 treated as one frame
        model_frame(1, 2, 1, 1);
        chk("mdl_roi_size", 32'(mdl.size()), 32'd1);
        chk("mdl_roi_w0", mdl[0], 32'h00000A09);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        do_start(8'd0, 1, 2, 1, 1);
        send_frame(fv);
        wait_idle("roi");
        chk("roi_frames_done", 32'(frames_done), 32'd1);
        chk("roi_words_left", 32'(exp_q.size()), 32'd0);

        // empty window x0>x1: no words at all
        model_frame(3, 2, 0, FL - 1);
        chk("mdl_empty_size", 32'(mdl.size()), 32'd0);
        do_start(8'd1, 3, 2, 0, FL - 1);
        send_frame(fv);
        wait_idle("empty");
        chk("empty_frames_done", 32'(frames_done), 32'd1);

        // burst of three frames
        model_frame(0, LP - 1, 0, FL - 1);
        p0 = req_pulses;
        do_start(8'd3, 0, LP - 1, 0, FL - 1);
        for (int f = 0; f < 3; f++) begin
            foreach (mdl[i]) exp_q.push_back(mdl[i]);
            send_frame(fv);
            chk("burst_frames_done", 32'(frames_done), 32'(f + 1));
        end
        wait_idle("burst");
        chk("burst_req_pulses", 32'(req_pulses - p0), 32'd3);
        chk("burst_busy", 32'(busy), 32'd0);
        chk("burst_words_left", 32'(exp_q.size()), 32'd0);

        // backpressure for a whole frame: only the first word survives
        word_ready = 1'b0;
        model_frame(0, LP - 1, 0, FL - 1);
        exp_q.push_back(mdl[0]);
        do_start(8'd1, 0, LP - 1, 0, FL - 1);
        send_frame(fv);
        wait_idle("bp");
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_word_valid", 32'(word_valid), 32'd1);
        chk("bp_word_data", word_data, 32'h03020100);
        word_ready = 1'b1;
        repeat (2) step();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        do_start(8'd1, 0, LP - 1, 0, FL - 1);
        chk("bp_overflow_cleared", 32'(overflow), 32'd0);
        send_frame(fv);
        wait_idle("bp2");
        chk("bp2_words_left", 32'(exp_q.size()), 32'd0);

        // abort in the second frame of a burst after 5 pixels, with a word pending
        model_frame(0, LP - 1, 0, FL - 1);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        do_start(8'd2, 0, LP - 1, 0, FL - 1);
        send_frame(fv);
        chk("ab_frames_done_pre", 32'(frames_done), 32'd1);
        wait_cap();
        word_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            lv = 1'b1;
            dv = 1'b1;
            CVM_D = PIX_W'(c << 2);
            step();
        end
        chk("ab_pending_before", 32'(word_valid), 32'd1);
        abort = 1'b1;
        lv = 1'b0;
        dv = 1'b0;
        CVM_D = '0;
        step();
        abort = 1'b0;
        chk("ab_word_valid", 32'(word_valid), 32'd0);
        chk("ab_fifo_reset", 32'(fifo_reset), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_frames_done_kept", 32'(frames_done), 32'd1);
        word_ready = 1'b1;
        repeat (2) step();
        chk("ab_words_left", 32'(exp_q.size()), 32'd0);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        do_start(8'd1, 0, LP - 1, 0, FL - 1);
        send_frame(fv);
        wait_idle("ab_clean");
        chk("ab_clean_frames_done", 32'(frames_done), 32'd1);
        chk("ab_clean_words_left", 32'(exp_q.size()), 32'd0);

        // reset mid-burst restarts power-up
        mon_en = 1'b0;
        do_start(8'd2, 0, LP - 1, 0, FL - 1);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_sys_res_n", 32'(SYS_RES_N), 32'd0);
        chk("mid_rst_spi_ready", 32'(spi_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fifo_reset", 32'(fifo_reset), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
